rr_output_port_allocator: RTL and testbench

//  Round-robin, packet-locked allocator for one router output port.

---
 rtl/rr_output_port_allocator_if.sv | 25 ++
 rtl/rr_output_port_allocator.sv | 79 +++++++
 tb/tb_rr_output_port_allocator.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/rr_output_port_allocator_if.sv
// rr_output_port_allocator_if: request/grant/credit bundle between input buffers and one output port allocator
interface rr_output_port_allocator_if #(
    parameter int N       = 5,
    parameter int CREDITS = 4
);
    localparam int IDW = $clog2(N);
    localparam int CW  = $clog2(CREDITS + 1);
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_tail;
    logic           credit_in;
    logic [N-1:0]   gnt;
    logic [IDW-1:0] gnt_id;
    logic [N-1:0]   in_ready;
    logic           fire;
    logic [CW-1:0]  credits;
    logic           credit_err;
    modport master (
        output in_valid, in_tail, credit_in,
        input  gnt, gnt_id, in_ready, fire, credits, credit_err
    );
    modport slave (
        input  in_valid, in_tail, credit_in,
        output gnt, gnt_id, in_ready, fire, credits, credit_err
    );
endinterface

// File: rtl/rr_output_port_allocator.sv
// rr_output_port_allocator: round-robin, packet-locked, credit-gated allocator for one router output port
module rr_output_port_allocator #(
    parameter int N       = 5,
    parameter int CREDITS = 4
) (
    input logic clk,
    input logic rst,
    rr_output_port_allocator_if.slave bus
);
    localparam int IDW = $clog2(N);
    localparam int CW  = $clog2(CREDITS + 1);
    typedef enum logic {IDLE, LOCKED} state_t;
    state_t         state;
    logic [N-1:0]   gnt;
    logic [IDW-1:0] gnt_id;
    logic [IDW-1:0] ptr;
    logic [CW-1:0]  credits;
    logic           credit_err;
    logic [N-1:0]   in_ready;
    logic           fire;
    logic [IDW-1:0] win;
    logic           found;
    // first requester at or after ptr, wrapping modulo N
    always_comb begin
        win   = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!found && bus.in_valid[(int'(ptr) + k) % N]) begin
                found = 1'b1;
                win   = IDW'((int'(ptr) + k) % N);
            end
        end
    end
    // transfers only from the locked input with credit; suppressed while in reset
    always_comb begin
        in_ready = rst ? '0 : gnt & {N{credits != '0}};
        fire     = |(bus.in_valid & in_ready);
    end
    // arbitration FSM: grab a winner when idle, hold it until its tail fires
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            gnt    <= '0;
            gnt_id <= '0;
            ptr    <= '0;
        end else if (state == IDLE) begin
            if (found) begin
                state  <= LOCKED;
                gnt    <= N'(1) << win;
                gnt_id <= win;
            end
        end else if (fire && bus.in_tail[gnt_id]) begin
            state  <= IDLE;
            gnt    <= '0;
            gnt_id <= '0;
            ptr    <= (gnt_id == IDW'(N - 1)) ? '0 : gnt_id + 1'b1;
        end
    end
    // downstream credit counter; a return at full count is flagged, not counted
    always_ff @(posedge clk) begin
        if (rst) begin
            credits    <= CW'(CREDITS);
            credit_err <= 1'b0;
        end else if (fire && !bus.credit_in) begin
            credits <= credits - 1'b1;
        end else if (bus.credit_in && !fire) begin
            if (credits == CW'(CREDITS))
                credit_err <= 1'b1;
            else
                credits <= credits + 1'b1;
        end
    end
    assign bus.gnt        = gnt;
    assign bus.gnt_id     = gnt_id;
    assign bus.in_ready   = in_ready;
    assign bus.fire       = fire;
    assign bus.credits    = credits;
    assign bus.credit_err = credit_err;
endmodule

// File: tb/tb_rr_output_port_allocator.sv
// tb_rr_output_port_allocator: directed scenarios plus randomized run against a behavioural allocator model
module tb_rr_output_port_allocator;
    localparam int N       = 5;
    localparam int CREDITS = 4;
    localparam int IDW     = $clog2(N);
    localparam int CW      = $clog2(CREDITS + 1);

    logic clk = 1'b0;
    logic rst = 1'b1;
    rr_output_port_allocator_if #(.N(N), .CREDITS(CREDITS)) bus ();
    rr_output_port_allocator #(.N(N), .CREDITS(CREDITS)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // behavioural model: packet lock owner, rotating start point, credit count
    bit m_locked = 0;
    int m_owner  = 0;
    int m_ptr    = 0;
    int m_cred   = CREDITS;
    bit m_err    = 0;

    logic [N-1:0]   exp_gnt, exp_ready, obs_gnt, obs_ready;
    logic [IDW-1:0] exp_id, obs_id;
    logic [CW-1:0]  exp_cred, obs_cred;
    logic           exp_fire, exp_err, obs_fire, obs_err;

    task automatic tick(input logic [N-1:0] v, input logic [N-1:0] t, input logic c, input logic r);
        bit fnd;
        bus.in_valid  = v;
        bus.in_tail   = t;
        bus.credit_in = c;
        rst           = r;
        @(negedge clk);
        obs_gnt   = bus.gnt;
        obs_id    = bus.gnt_id;
        obs_ready = bus.in_ready;
        obs_fire  = bus.fire;
        obs_cred  = bus.credits;
        obs_err   = bus.credit_err;
        exp_gnt   = m_locked ? N'(1) << m_owner : '0;
        exp_id    = m_locked ? IDW'(m_owner) : '0;
        exp_fire  = !r && m_locked && v[m_owner] && m_cred > 0;
        exp_ready = (!r && m_cred > 0) ? exp_gnt : '0;
        exp_cred  = CW'(m_cred);
        exp_err   = m_err;
        if (r) begin
            m_locked = 0; m_owner = 0; m_ptr = 0; m_cred = CREDITS; m_err = 0;
        end else begin
            if (!m_locked) begin
                fnd = 0;
                for (int k = 0; k < N; k++)
                    if (!fnd && v[(m_ptr + k) % N]) begin
                        fnd = 1; m_locked = 1; m_owner = (m_ptr + k) % N;
                    end
            end else if (exp_fire && t[m_owner]) begin
                m_locked = 0;
                m_ptr    = (m_owner + 1) % N;
            end
            if (exp_fire && !c) m_cred--;
            else if (c && !exp_fire) begin
                if (m_cred == CREDITS) m_err = 1;
                else m_cred++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tick('0, '0, 1'b0, 1'b1);
        tick('0, '0, 1'b0, 1'b1);
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (obs_fire !== 1'b0) begin errors++; $display("FAIL reset_cycle_fire got=%b exp=0", obs_fire); end
        tick('0, '0, 1'b0, 1'b0);
        checks++; if (obs_gnt !== 5'b00000) begin errors++; $display("FAIL reset_gnt got=%b exp=00000", obs_gnt); end
        checks++; if (obs_id !== 3'd0) begin errors++; $display("FAIL reset_gnt_id got=%0d exp=0", obs_id); end
        checks++; if (obs_cred !== 3'd4) begin errors++; $display("FAIL reset_credits got=%0d exp=4", obs_cred); end
        checks++; if (obs_err !== 1'b0) begin errors++; $display("FAIL reset_credit_err got=%b exp=0", obs_err); end
        checks++; if (obs_fire !== 1'b0) begin errors++; $display("FAIL reset_fire got=%b exp=0", obs_fire); end
    endtask

    task automatic test_packet_lock();
        do_reset();
        tick(5'b00101, '0, 1'b0, 1'b0);
        checks++; if (obs_gnt !== 5'b00000) begin errors++; $display("FAIL lock_arb_latency got=%b exp=00000", obs_gnt); end
        for (int i = 0; i < 3; i++) begin
            tick(5'b00101, (i == 2) ? 5'b00001 : 5'b00000, 1'b1, 1'b0);
            checks++; if (obs_gnt !== 5'b00001) begin errors++; $display("FAIL lock_gnt flit%0d got=%b exp=00001", i, obs_gnt); end
            checks++; if (obs_fire !== 1'b1) begin errors++; $display("FAIL lock_fire flit%0d got=%b exp=1", i, obs_fire); end
        end
        tick(5'b00101, '0, 1'b0, 1'b0);
        checks++; if (obs_gnt !== 5'b00000) begin errors++; $display("FAIL lock_gap got=%b exp=00000", obs_gnt); end
        tick(5'b00101, '0, 1'b0, 1'b0);
        checks++; if (obs_gnt !== 5'b00100) begin errors++; $display("FAIL lock_next_gnt got=%b exp=00100", obs_gnt); end
        checks++; if (obs_id !== 3'd2) begin errors++; $display("FAIL lock_next_id got=%0d exp=2", obs_id); end
    endtask

    task automatic test_back_to_back();
        logic [N-1:0]   eg;
        logic [IDW-1:0] ei;
        do_reset();
        for (int k = 0; k < 12; k++) begin
            tick(5'b11111, 5'b11111, 1'b1, 1'b0);
            ei = IDW'(((k - 1) / 2) % N);
            eg = (k % 2 == 1) ? N'(1) << ei : '0;
            checks++; if (obs_gnt !== eg) begin errors++; $display("FAIL b2b_gnt c%0d got=%b exp=%b", k, obs_gnt, eg); end
            if (k % 2 == 1) begin
                checks++; if (obs_id !== ei) begin errors++; $display("FAIL b2b_id c%0d got=%0d exp=%0d", k, obs_id, ei); end
            end
        end
    endtask

    task automatic test_credit_block();
        int fires = 0;
        do_reset();
        tick(5'b00010, '0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick(5'b00010, '0, 1'b0, 1'b0);
            fires += int'(obs_fire);
            checks++; if (obs_fire !== 1'b1) begin errors++; $display("FAIL cred_fire flit%0d got=%b exp=1", i, obs_fire); end
        end
        tick(5'b00010, '0, 1'b0, 1'b0);
        fires += int'(obs_fire);
        checks++; if (obs_cred !== 3'd0) begin errors++; $display("FAIL cred_empty got=%0d exp=0", obs_cred); end
        checks++; if (obs_ready !== 5'b00000) begin errors++; $display("FAIL cred_ready got=%b exp=00000", obs_ready); end
        tick(5'b00010, '0, 1'b1, 1'b0);
        fires += int'(obs_fire);
        tick(5'b00010, '0, 1'b0, 1'b0);
        fires += int'(obs_fire);
        checks++; if (obs_fire !== 1'b1) begin errors++; $display("FAIL cred_refire got=%b exp=1", obs_fire); end
        tick(5'b00010, '0, 1'b0, 1'b0);
        fires += int'(obs_fire);
        checks++; if (fires !== 5) begin errors++; $display("FAIL cred_total_fires got=%0d exp=5", fires); end
        checks++; if (obs_gnt !== 5'b00010) begin errors++; $display("FAIL cred_lock_held got=%b exp=00010", obs_gnt); end
    endtask

    task automatic test_credit_edges();
        do_reset();
        tick(5'b00001, '0, 1'b0, 1'b0);
        tick(5'b00001, '0, 1'b0, 1'b0);
        tick(5'b00001, '0, 1'b0, 1'b0);
        tick(5'b00001, '0, 1'b1, 1'b0);
        checks++; if (obs_fire !== 1'b1 || obs_cred !== 3'd2) begin errors++; $display("FAIL edge_both fire=%b credits=%0d exp fire=1 credits=2", obs_fire, obs_cred); end
        tick('0, '0, 1'b1, 1'b0);
        checks++; if (obs_cred !== 3'd2) begin errors++; $display("FAIL edge_both_after got=%0d exp=2", obs_cred); end
        tick('0, '0, 1'b1, 1'b0);
        tick('0, '0, 1'b1, 1'b0);
        checks++; if (obs_cred !== 3'd4 || obs_err !== 1'b0) begin errors++; $display("FAIL edge_full credits=%0d err=%b exp credits=4 err=0", obs_cred, obs_err); end
        tick('0, '0, 1'b0, 1'b0);
        checks++; if (obs_cred !== 3'd4) begin errors++; $display("FAIL edge_saturate got=%0d exp=4", obs_cred); end
        checks++; if (obs_err !== 1'b1) begin errors++; $display("FAIL edge_credit_err got=%b exp=1", obs_err); end
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        tick(5'b01000, 5'b01000, 1'b0, 1'b0);
        tick(5'b01000, 5'b01000, 1'b0, 1'b0);
        checks++; if (obs_gnt !== 5'b01000 || obs_fire !== 1'b1) begin errors++; $display("FAIL mid_single gnt=%b fire=%b exp gnt=01000 fire=1", obs_gnt, obs_fire); end
        tick(5'b00100, '0, 1'b0, 1'b0);
        tick(5'b00100, '0, 1'b0, 1'b0);
        checks++; if (obs_gnt !== 5'b00100) begin errors++; $display("FAIL mid_lock got=%b exp=00100", obs_gnt); end
        tick(5'b00100, '0, 1'b0, 1'b1);
        checks++; if (obs_fire !== 1'b0) begin errors++; $display("FAIL mid_rst_fire got=%b exp=0", obs_fire); end
        tick(5'b11111, '0, 1'b0, 1'b0);
        checks++; if (obs_gnt !== 5'b00000) begin errors++; $display("FAIL mid_after_gnt got=%b exp=00000", obs_gnt); end
        checks++; if (obs_cred !== 3'd4) begin errors++; $display("FAIL mid_after_credits got=%0d exp=4", obs_cred); end
        tick(5'b11111, '0, 1'b0, 1'b0);
        checks++; if (obs_gnt !== 5'b00001 || obs_id !== 3'd0) begin errors++; $display("FAIL mid_ptr_reset gnt=%b id=%0d exp gnt=00001 id=0", obs_gnt, obs_id); end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            tick(N'($urandom), N'($urandom & $urandom), $urandom_range(0, 2) == 0, $urandom_range(0, 99) == 0);
            checks++; if (obs_gnt !== exp_gnt) begin errors++; $display("FAIL rnd_gnt c%0d got=%b exp=%b", c, obs_gnt, exp_gnt); end
            checks++; if (obs_id !== exp_id) begin errors++; $display("FAIL rnd_id c%0d got=%0d exp=%0d", c, obs_id, exp_id); end
            checks++; if (obs_ready !== exp_ready) begin errors++; $display("FAIL rnd_ready c%0d got=%b exp=%b", c, obs_ready, exp_ready); end
            checks++; if (obs_fire !== exp_fire) begin errors++; $display("FAIL rnd_fire c%0d got=%b exp=%b", c, obs_fire, exp_fire); end
            checks++; if (obs_cred !== exp_cred) begin errors++; $display("FAIL rnd_credits c%0d got=%0d exp=%0d", c, obs_cred, exp_cred); end
            checks++; if (obs_err !== exp_err) begin errors++; $display("FAIL rnd_err c%0d got=%b exp=%b", c, obs_err, exp_err); end
        end
    endtask

    initial begin
        bus.in_valid  = '0;
        bus.in_tail   = '0;
        bus.credit_in = 1'b0;
        test_reset();
        test_packet_lock();
        test_back_to_back();
        test_credit_block();
        test_credit_edges();
        test_reset_mid_packet();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
